// File: rtl/pll_freq_monitor.sv
// PLL output frequency monitor: counts synchronised rising edges of mon_toggle
// per fixed reference window and qualifies lock after consecutive good windows.
module pll_freq_monitor #(
    parameter int WINDOW       = 4096,
    parameter int CNT_W        = 16,
    parameter int EXP_MIN      = 1990,
    parameter int EXP_MAX      = 2010,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             mon_toggle,
    output logic [CNT_W-1:0] freq_count,
    output logic             count_valid,
    output logic             in_range,
    output logic             locked,
    output logic             lost
);
    localparam int WCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

    localparam logic [WCNT_W-1:0] WLAST    = WCNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  MIN_C    = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0]  MAX_C    = CNT_W'(EXP_MAX);
    localparam logic [GOOD_W-1:0] GOOD_TGT = GOOD_W'(LOCK_WINDOWS);

    typedef enum logic {
        ST_ACQ    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Saturating increment: a runaway input pins the count at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic inc);
        if (inc && (v != CNT_MAX))
            return v + CNT_W'(1);
        return v;
    endfunction

    function automatic logic range_ok(input logic [CNT_W-1:0] v);
        return (v >= MIN_C) && (v <= MAX_C);
    endfunction

    logic              tog_p0, tog_p1, tog_p2;
    logic              strobe;
    logic [WCNT_W-1:0] wcnt;
    logic [CNT_W-1:0]  ecnt;
    logic [CNT_W-1:0]  final_cnt;
    logic              win_end;
    logic              win_ok;

    state_t            state, state_nxt;
    logic [GOOD_W-1:0] good, good_nxt;
    logic              lost_nxt;

    assign strobe    = tog_p1 & ~tog_p2;
    assign win_end   = (wcnt == WLAST);
    assign final_cnt = sat_inc(ecnt, strobe);
    assign win_ok    = range_ok(final_cnt);
    assign locked    = (state == ST_LOCKED);

    // Stage p0/p1 synchronise, p2 holds history for edge detection; the
    // window count and result registers follow the strobe.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tog_p0      <= 1'b0;
            tog_p1      <= 1'b0;
            tog_p2      <= 1'b0;
            wcnt        <= '0;
            ecnt        <= '0;
            freq_count  <= '0;
            count_valid <= 1'b0;
            in_range    <= 1'b0;
            lost        <= 1'b0;
            state       <= ST_ACQ;
            good        <= '0;
        end else begin
            tog_p0      <= mon_toggle;
            tog_p1      <= tog_p0;
            tog_p2      <= tog_p1;
            count_valid <= win_end;
            lost        <= lost_nxt;
            state       <= state_nxt;
            good        <= good_nxt;
            if (win_end) begin
                wcnt       <= '0;
                ecnt       <= '0;
                freq_count <= final_cnt;
                in_range   <= win_ok;
            end else begin
                wcnt <= wcnt + WCNT_W'(1);
                ecnt <= final_cnt;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        lost_nxt  = 1'b0;
        if (win_end) begin
            case (state)
                ST_ACQ: begin
                    if (!win_ok) begin
                        good_nxt = '0;
                    end else if (good >= GOOD_TGT - GOOD_W'(1)) begin
                        good_nxt  = GOOD_TGT;
                        state_nxt = ST_LOCKED;
                    end else begin
                        good_nxt = good + GOOD_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!win_ok) begin
                        state_nxt = ST_ACQ;
                        good_nxt  = '0;
                        lost_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_ACQ;
                    good_nxt  = '0;
                end
            endcase
        end
    end

endmodule
